seg_display_mux: RTL and testbench

SEG_DISPLAY_MUX -- requirements
Module: seg_display_mux

---
 rtl/seg_pkg.sv | 33 +++
 rtl/seg_hex_decode.sv | 15 +
 rtl/seg_display_mux.sv | 147 ++++++++++++++
 tb/tb_seg_display_mux.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display multiplexer.
//   SEG_FONT  : 16-entry hex font, active-low, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK : all segments off (active-low)
//   ANODE_OFF : all digit enables off (active-low), sliced to NUM_DIGITS by users
package seg_pkg;

    localparam int unsigned MAX_DIGITS = 16;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = {MAX_DIGITS{1'b1}};

    // Entry N is the glyph for nibble N; listed from F down to 0.
    localparam logic [15:0][6:0] SEG_FONT = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-seven-segment decoder.
//   nibble : 4-bit hex value
//   seg    : active-low segments {g,f,e,d,c,b,a}
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_FONT[nibble];
    end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed seven-segment display driver with frame-synchronous data
// update, leading-zero suppression and PWM brightness.
//   clk, rst   : system clock, asynchronous active-high reset
//   data_in    : hex nibbles, digit 0 in bits [3:0]
//   dp_in      : decimal-point request per digit (active-high)
//   load       : one-cycle strobe capturing data_in/dp_in
//   enable     : display on when 1
//   blank_lz   : suppress leading zeros when 1
//   brightness : PWM duty code; all ones = fully on, 0 = dark
//   segment    : active-low cathodes {g,f,e,d,c,b,a}
//   dp         : active-low decimal-point cathode
//   anode      : active-low one-hot digit enables
//   frame_done : one-cycle pulse when the digit index wraps to 0
module seg_display_mux
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned DIGIT_HZ   = 1000,
    parameter int unsigned BRIGHT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    enable,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              segment,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_done
);

    localparam int unsigned TICK_DIV = CLK_HZ / DIGIT_HZ;
    localparam int unsigned PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = ANODE_OFF[NUM_DIGITS-1:0];

    logic [PRESC_W-1:0]      presc;
    logic [IDX_W-1:0]        digit_idx;
    logic [BRIGHT_W-1:0]     pwm_cnt;
    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_valid;
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    logic             tick;
    logic             wrap;
    logic [3:0]       cur_nibble;
    logic             cur_dp;
    logic [6:0]       cur_font;
    logic [IDX_W-1:0] hi_nz;
    logic             blank_cur;
    logic             pwm_on;

    assign tick = (presc == PRESC_LAST);
    assign wrap = tick && (digit_idx == IDX_LAST);

    // Scan timebase, PWM counter and frame pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            digit_idx  <= '0;
            pwm_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + 1'b1;
            pwm_cnt    <= pwm_cnt + 1'b1;
            frame_done <= wrap;
            if (tick) begin
                digit_idx <= wrap ? '0 : digit_idx + 1'b1;
            end
        end
    end

    // Double buffering: the shadow only changes at a frame wrap so one frame
    // never mixes two loads. A load landing on the wrap cycle goes straight
    // to the shadow instead of waiting a whole extra frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_data   <= '0;
            pend_dp     <= '0;
            pend_valid  <= 1'b0;
            shadow_data <= '0;
            shadow_dp   <= '0;
        end else begin
            if (load) begin
                pend_data <= data_in;
                pend_dp   <= dp_in;
            end
            if (wrap && load) begin
                shadow_data <= data_in;
                shadow_dp   <= dp_in;
                pend_valid  <= 1'b0;
            end else if (wrap && pend_valid) begin
                shadow_data <= pend_data;
                shadow_dp   <= pend_dp;
                pend_valid  <= 1'b0;
            end else if (load) begin
                pend_valid <= 1'b1;
            end
        end
    end

    seg_hex_decode u_hex_decode (
        .nibble (cur_nibble),
        .seg    (cur_font)
    );

    always_comb begin
        cur_nibble = shadow_data[{digit_idx, 2'b00} +: 4];
        cur_dp     = shadow_dp[digit_idx];
        // Index of the most significant nonzero nibble; 0 when all are zero,
        // which keeps digit 0 always visible.
        hi_nz = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (shadow_data[i*4 +: 4] != 4'h0) begin
                hi_nz = IDX_W'(i);
            end
        end
        blank_cur = blank_lz && (digit_idx > hi_nz) && !cur_dp;
        pwm_on    = (brightness == '1) || (brightness > pwm_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segment <= SEG_BLANK;
            dp      <= 1'b1;
            anode   <= AN_OFF;
        end else if (!enable) begin
            segment <= SEG_BLANK;
            dp      <= 1'b1;
            anode   <= AN_OFF;
        end else begin
            segment <= blank_cur ? SEG_BLANK : cur_font;
            dp      <= blank_cur ? 1'b1 : ~cur_dp;
            anode   <= pwm_on ? ~(NUM_DIGITS'(1) << digit_idx) : AN_OFF;
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux (4 digits, 10 clk per digit, 4-bit PWM).
// The stimulus process pushes the expected contents of a whole frame at the
// frame_done that starts it; the monitor captures every frame mid-digit and
// compares against the queue head when one is waiting.
module tb_seg_display_mux;

    localparam int unsigned ND = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        enable;
    logic        blank_lz;
    logic [3:0]  brightness;
    logic [6:0]  segment;
    logic        dp;
    logic [3:0]  anode;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string           name;
        logic [3:0][6:0] seg;   // {digit3, digit2, digit1, digit0}
        logic [3:0]      dpn;   // expected dp output per digit (active-low)
        logic [3:0]      care;  // digits to compare
    } frame_t;

    frame_t exp_q[$];

    always #5 clk = ~clk;

    seg_display_mux #(
        .NUM_DIGITS (ND),
        .CLK_HZ     (1000),
        .DIGIT_HZ   (100),
        .BRIGHT_W   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .enable     (enable),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .segment    (segment),
        .dp         (dp),
        .anode      (anode),
        .frame_done (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic wait_fd(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        check({name, "_frame_done"}, 32'(frame_done), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        data_in = d;
        dp_in   = p;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic push(input string name, input logic [3:0][6:0] s, input logic [3:0] dpn,
                        input logic [3:0] care);
        frame_t f;
        f.name = name;
        f.seg  = s;
        f.dpn  = dpn;
        f.care = care;
        exp_q.push_back(f);
    endtask

    task automatic check_blank_now(input string name);
        check({name, "_anode"}, 32'(anode), 32'hF);
        check({name, "_seg"}, 32'(segment), 32'h7F);
        check({name, "_dp"}, 32'(dp), 32'd1);
        check({name, "_fd"}, 32'(frame_done), 32'd0);
    endtask

    // Monitor: sample each digit in the middle of its 10-clk slot.
    initial begin : monitor
        logic [3:0] an_s  [ND];
        logic [6:0] seg_s [ND];
        logic       dp_s  [ND];
        frame_t     e;
        forever begin
            @(negedge clk);
            if (frame_done && !rst) begin
                repeat (5) @(negedge clk);
                for (int d = 0; d < ND; d++) begin
                    an_s[d]  = anode;
                    seg_s[d] = segment;
                    dp_s[d]  = dp;
                    if (d < ND - 1) repeat (10) @(negedge clk);
                end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    for (int d = 0; d < ND; d++) begin
                        if (e.care[d]) begin
                            check($sformatf("%s_d%0d_anode", e.name, d), 32'(an_s[d]),
                                  32'hF ^ (32'h1 << d));
                            check($sformatf("%s_d%0d_seg", e.name, d), 32'(seg_s[d]),
                                  32'(e.seg[d]));
                            check($sformatf("%s_d%0d_dp", e.name, d), 32'(dp_s[d]),
                                  32'(e.dpn[d]));
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int n;
        int bad;
        rst        = 1'b1;
        data_in    = '0;
        dp_in      = '0;
        load       = 1'b0;
        enable     = 1'b0;
        blank_lz   = 1'b0;
        brightness = '0;
        repeat (3) @(negedge clk);
        check_blank_now("reset");

        // Release: first frame shows zeros.
        brightness = 4'hF;
        enable     = 1'b1;
        rst        = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_d0_anode", 32'(anode), 32'hE);
        check("post_rst_d0_seg", 32'(segment), 32'h40);
        check("post_rst_d0_dp", 32'(dp), 32'd1);

        wait_fd("first");
        push("zeros", {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'hF, 4'hF);
        @(negedge clk);
        check("fd_pulse_width", 32'(frame_done), 32'd0);
        n = 1;
        while (!frame_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("fd_period", 32'(n), 32'd40);

        // Scan of 1234.
        do_load(16'h1234, 4'h0);
        wait_fd("scan");
        push("scan_1234", {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'hF, 4'hF);

        // Mid-frame load must not disturb the frame in progress.
        repeat (14) @(negedge clk);
        do_load(16'hABCD, 4'h0);
        wait_fd("sync");
        push("sync_abcd", {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}, 4'hF, 4'hF);

        // Leading-zero blanking.
        repeat (2) @(negedge clk);
        blank_lz = 1'b1;
        do_load(16'h0070, 4'h0);
        wait_fd("lz");
        push("lz_0070", {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}, 4'hF, 4'hF);
        repeat (2) @(negedge clk);
        do_load(16'h0070, 4'b1000);
        wait_fd("lz_dp");
        push("lz_dp", {7'b1000000, 7'b1111111, 7'b1111000, 7'b1000000}, 4'b0111, 4'b1011);
        wait_fd("lz_done");
        blank_lz = 1'b0;

        // Load on the wrap cycle lands in the very next frame.
        repeat (39) @(negedge clk);
        data_in = 16'h5555;
        dp_in   = 4'h0;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        check("wrap_load_fd", 32'(frame_done), 32'd1);
        push("wrap_5555", {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010}, 4'hF, 4'hF);
        wait_fd("wrap_done");

        // PWM duty.
        brightness = 4'd4;
        repeat (2) @(negedge clk);
        n   = 0;
        bad = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (anode != 4'hF) n++;
            if (!(anode inside {4'hE, 4'hD, 4'hB, 4'h7, 4'hF})) bad++;
        end
        check("pwm4_on_cycles", 32'(n), 32'd40);
        check("pwm4_onehot", 32'(bad), 32'd0);
        brightness = 4'd0;
        repeat (2) @(negedge clk);
        n = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (anode != 4'hF) n++;
        end
        check("pwm0_on_cycles", 32'(n), 32'd0);

        // Disabled: dark outputs, loads still accepted.
        brightness = 4'hF;
        enable     = 1'b0;
        repeat (2) @(negedge clk);
        do_load(16'h8888, 4'h0);
        bad = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (anode != 4'hF || segment != 7'h7F || dp != 1'b1) bad++;
        end
        check("disabled_dark", 32'(bad), 32'd0);
        enable = 1'b1;
        wait_fd("reenable");
        push("after_disable_8888", {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}, 4'hF,
             4'hF);
        wait_fd("reenable_done");

        // Reset mid-digit with a load still pending.
        repeat (3) @(negedge clk);
        do_load(16'h9999, 4'hF);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_blank_now("mid_reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst2_d0_anode", 32'(anode), 32'hE);
        check("rst2_d0_seg", 32'(segment), 32'h40);
        check("rst2_d0_dp", 32'(dp), 32'd1);
        wait_fd("rst2");
        push("zeros_after_rst2", {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'hF, 4'hF);

        n = 0;
        while (exp_q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
